// File: rtl/packet_buf_sched.sv
// Ownership scheduler for a ring of packet buffers shared by the snooper,
// the filter CPU and the forwarder. Every client walks the ring in the same
// order, so packets leave in the order they arrived.
module packet_buf_sched #(
  parameter int NBUF = 3,
  parameter int SELW = $clog2(NBUF),
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            snooper_done,
  output logic            ready_for_snooper,
  output logic [SELW-1:0] snooper_buf_sel,
  output logic            cpu_start,
  output logic [SELW-1:0] cpu_buf_sel,
  input  logic            cpu_accept,
  input  logic            cpu_reject,
  input  logic            forwarder_done,
  output logic            ready_for_forwarder,
  output logic [SELW-1:0] forwarder_buf_sel,
  output logic [CNTW-1:0] fwd_count,
  output logic [CNTW-1:0] drop_count
);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLED   = 2'd1,
    ACCEPTED = 2'd2,
    DROP     = 2'd3
  } buf_state_t;

  buf_state_t      st [NBUF];
  logic [SELW-1:0] snoop_ptr;
  logic [SELW-1:0] cpu_ptr;
  logic [SELW-1:0] fwd_ptr;
  logic            cpu_busy;
  logic            cpu_start_r;

  logic snoop_wr;
  logic cpu_res;
  logic cpu_drop;
  logic cpu_launch;
  logic fwd_take;
  logic fwd_skip;

  // Ring pointers wrap explicitly so NBUF need not be a power of two.
  function automatic logic [SELW-1:0] ptr_inc(input logic [SELW-1:0] p);
    if (p == SELW'(NBUF - 1)) return '0;
    return p + SELW'(1);
  endfunction

  // Per-client events decoded from registered state. Each write condition
  // requires a different current buffer state, so in any one cycle the three
  // clients can only ever touch distinct buffers.
  always_comb begin
    snoop_wr   = snooper_done && (st[snoop_ptr] == FREE);
    // A result arriving in the launch cycle belongs to no packet yet.
    cpu_res    = cpu_busy && !cpu_start_r && (cpu_accept || cpu_reject);
    // Reject wins when both pulses arrive together.
    cpu_drop   = cpu_res && cpu_reject;
    cpu_launch = !cpu_busy && !cpu_start_r && (st[cpu_ptr] == FILLED);
    fwd_take   = forwarder_done && (st[fwd_ptr] == ACCEPTED);
    // Dropped buffers are reclaimed without involving the forwarder.
    fwd_skip   = (st[fwd_ptr] == DROP);
  end

  assign ready_for_snooper   = (st[snoop_ptr] == FREE);
  assign ready_for_forwarder = (st[fwd_ptr] == ACCEPTED);
  assign snooper_buf_sel     = snoop_ptr;
  assign cpu_buf_sel         = cpu_ptr;
  assign forwarder_buf_sel   = fwd_ptr;
  assign cpu_start           = cpu_start_r;

  // Buffer state ring and the three ownership pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBUF; i++) st[i] <= FREE;
      snoop_ptr <= '0;
      cpu_ptr   <= '0;
      fwd_ptr   <= '0;
    end else begin
      if (snoop_wr) begin
        st[snoop_ptr] <= FILLED;
        snoop_ptr     <= ptr_inc(snoop_ptr);
      end
      if (cpu_res) begin
        st[cpu_ptr] <= cpu_drop ? DROP : ACCEPTED;
        cpu_ptr     <= ptr_inc(cpu_ptr);
      end
      if (fwd_take || fwd_skip) begin
        st[fwd_ptr] <= FREE;
        fwd_ptr     <= ptr_inc(fwd_ptr);
      end
    end
  end

  // CPU handshake: one-cycle start pulse, busy until a result comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_start_r <= 1'b0;
      cpu_busy    <= 1'b0;
    end else begin
      cpu_start_r <= cpu_launch;
      if (cpu_launch)   cpu_busy <= 1'b1;
      else if (cpu_res) cpu_busy <= 1'b0;
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (fwd_take) fwd_count  <= fwd_count + CNTW'(1);
      if (cpu_drop) drop_count <= drop_count + CNTW'(1);
    end
  end

`ifndef SYNTHESIS
  // No two clients may write the same buffer in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(snoop_wr && cpu_res && (snoop_ptr == cpu_ptr)));
      assert (!(snoop_wr && (fwd_take || fwd_skip) && (snoop_ptr == fwd_ptr)));
      assert (!(cpu_res && (fwd_take || fwd_skip) && (cpu_ptr == fwd_ptr)));
    end
  end
`endif

endmodule

// File: tb/tb_packet_buf_sched.sv
// Directed bench for packet_buf_sched with NBUF=3.
module tb_packet_buf_sched;

  localparam int NBUF = 3;
  localparam int SELW = $clog2(NBUF);
  localparam int CNTW = 16;

  logic            clk;
  logic            rst;
  logic            snooper_done;
  logic            ready_for_snooper;
  logic [SELW-1:0] snooper_buf_sel;
  logic            cpu_start;
  logic [SELW-1:0] cpu_buf_sel;
  logic            cpu_accept;
  logic            cpu_reject;
  logic            forwarder_done;
  logic            ready_for_forwarder;
  logic [SELW-1:0] forwarder_buf_sel;
  logic [CNTW-1:0] fwd_count;
  logic [CNTW-1:0] drop_count;

  int n_tests;
  int n_fail;

  packet_buf_sched #(.NBUF(NBUF), .CNTW(CNTW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .snooper_done        (snooper_done),
    .ready_for_snooper   (ready_for_snooper),
    .snooper_buf_sel     (snooper_buf_sel),
    .cpu_start           (cpu_start),
    .cpu_buf_sel         (cpu_buf_sel),
    .cpu_accept          (cpu_accept),
    .cpu_reject          (cpu_reject),
    .forwarder_done      (forwarder_done),
    .ready_for_forwarder (ready_for_forwarder),
    .forwarder_buf_sel   (forwarder_buf_sel),
    .fwd_count           (fwd_count),
    .drop_count          (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    snooper_done = 1'b0;
    cpu_accept = 1'b0;
    cpu_reject = 1'b0;
    forwarder_done = 1'b0;

    // 1: reset state
    cyc(); cyc();
    chk("rst_rdy_snoop", ready_for_snooper, 1);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_rdy_fwd", ready_for_forwarder, 0);
    chk("rst_sels", {snooper_buf_sel, cpu_buf_sel, forwarder_buf_sel}, 0);
    chk("rst_counts", {fwd_count, drop_count}, 0);
    rst = 1'b0;

    // 2: first fill, then CPU launch one cycle later
    snooper_done = 1'b1;
    cyc(); snooper_done = 1'b0;
    chk("fill0_sel", snooper_buf_sel, 1);
    chk("fill0_no_start_yet", cpu_start, 0);
    cyc();
    chk("launch0_start", cpu_start, 1);
    chk("launch0_sel", cpu_buf_sel, 0);
    cyc();
    chk("launch0_pulse_len", cpu_start, 0);

    // 3: fill the ring, then an ignored extra fill
    snooper_done = 1'b1;
    cyc();
    chk("fill1_sel", snooper_buf_sel, 2);
    cyc(); snooper_done = 1'b0;
    chk("fill2_wrap_sel", snooper_buf_sel, 0);
    chk("full_rdy_snoop", ready_for_snooper, 0);
    snooper_done = 1'b1;
    cyc(); snooper_done = 1'b0;
    chk("full_ignored_sel", snooper_buf_sel, 0);
    chk("full_ignored_rdy", ready_for_snooper, 0);
    chk("busy_no_restart", cpu_start, 0);

    // 4: accept b0, reject b1, accept b2, forward in order
    cpu_accept = 1'b1;
    cyc(); cpu_accept = 1'b0;
    chk("acc0_rdy_fwd", ready_for_forwarder, 1);
    chk("acc0_fwd_sel", forwarder_buf_sel, 0);
    chk("acc0_cpu_ptr", cpu_buf_sel, 1);
    chk("acc0_gap", cpu_start, 0);
    cyc();
    chk("launch1_start", cpu_start, 1);
    chk("launch1_sel", cpu_buf_sel, 1);
    cyc();
    cpu_reject = 1'b1;
    cyc(); cpu_reject = 1'b0;
    chk("rej1_drop_count", drop_count, 1);
    chk("rej1_cpu_ptr", cpu_buf_sel, 2);
    forwarder_done = 1'b1;
    cyc(); forwarder_done = 1'b0;
    chk("fwd0_count", fwd_count, 1);
    chk("fwd0_sel", forwarder_buf_sel, 1);
    chk("skip1_rdy_fwd", ready_for_forwarder, 0);
    chk("freed0_rdy_snoop", ready_for_snooper, 1);
    chk("launch2_start", cpu_start, 1);
    chk("launch2_sel", cpu_buf_sel, 2);
    cyc();
    chk("skip1_sel", forwarder_buf_sel, 2);
    chk("skip1_still_not_rdy", ready_for_forwarder, 0);
    chk("skip1_fwd_count", fwd_count, 1);
    cpu_accept = 1'b1;
    cyc(); cpu_accept = 1'b0;
    chk("acc2_rdy_fwd", ready_for_forwarder, 1);
    forwarder_done = 1'b1;
    cyc(); forwarder_done = 1'b0;
    chk("fwd2_count", fwd_count, 2);
    chk("fwd2_drop_count", drop_count, 1);
    chk("fwd2_sel_wrap", forwarder_buf_sel, 0);

    // 5: simultaneous accept and reject is a drop
    snooper_done = 1'b1;
    cyc(); snooper_done = 1'b0;
    chk("refill0_sel", snooper_buf_sel, 1);
    cyc();
    chk("launch3_start", cpu_start, 1);
    chk("launch3_sel", cpu_buf_sel, 0);
    cyc();
    cpu_accept = 1'b1; cpu_reject = 1'b1;
    cyc(); cpu_accept = 1'b0; cpu_reject = 1'b0;
    chk("both_drop_count", drop_count, 2);
    chk("both_not_offered", ready_for_forwarder, 0);
    cyc();
    chk("both_skip_sel", forwarder_buf_sel, 1);
    chk("both_fwd_count", fwd_count, 2);
    chk("both_still_not_rdy", ready_for_forwarder, 0);

    // 6: asynchronous reset while the CPU is busy
    snooper_done = 1'b1;
    cyc(); snooper_done = 1'b0;
    cyc();
    chk("launch4_start", cpu_start, 1);
    chk("launch4_sel", cpu_buf_sel, 1);
    rst = 1'b1;
    #1;
    chk("arst_cpu_start", cpu_start, 0);
    chk("arst_rdy_fwd", ready_for_forwarder, 0);
    chk("arst_rdy_snoop", ready_for_snooper, 1);
    chk("arst_sels", {snooper_buf_sel, cpu_buf_sel, forwarder_buf_sel}, 0);
    chk("arst_counts", {fwd_count, drop_count}, 0);
    cyc();
    rst = 1'b0;
    cpu_accept = 1'b1;
    cyc(); cpu_accept = 1'b0;
    chk("post_rst_acc_ignored", ready_for_forwarder, 0);
    chk("post_rst_cpu_sel", cpu_buf_sel, 0);
    cyc();
    chk("post_rst_no_start", cpu_start, 0);
    chk("post_rst_rdy_snoop", ready_for_snooper, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
